// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory arbiter between
// the fetch (I) and load/store (D) ports.
package mem_arb_pkg;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive cycles the fetch side waits; flags starvation once the
// count saturates at MAX_WAIT so the arbiter can override D priority.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_ready,
    output logic starve
);

    localparam logic [7:0] LIMIT = 8'(MAX_WAIT);

    logic [7:0] cnt;

    // A grant or a withdrawn request both restart the wait measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (!req_valid || req_ready) begin
            cnt <= 8'd0;
        end else if (cnt != LIMIT) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign starve = (cnt == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch (I) and
// load/store (D); D has priority unless fetch has been starved for MAX_WAIT.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req_valid,
    input  logic [ADDR_W-1:0]   i_req_addr,
    output logic                i_req_ready,
    output logic                i_resp_valid,
    output logic [DATA_W-1:0]   i_resp_data,
    input  logic                d_req_valid,
    input  logic                d_req_we,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic [DATA_W-1:0]   d_req_wdata,
    input  logic [DATA_W/8-1:0] d_req_wmask,
    output logic                d_req_ready,
    output logic                d_resp_valid,
    output logic [DATA_W-1:0]   d_resp_data,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_we,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    output logic [DATA_W/8-1:0] mem_req_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_data,
    output logic                busy,
    output logic                protocol_err
);

    arb_state_e state;
    arb_state_e state_next;
    owner_e     owner;
    logic       starve;
    logic       grant_i;
    logic       grant_d;
    logic       grant_any;

    mem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (i_req_valid),
        .req_ready (i_req_ready),
        .starve    (starve)
    );

    // Starvation only matters when I is actually asking; otherwise D wins.
    assign grant_i   = i_req_valid && (starve || !d_req_valid);
    assign grant_d   = d_req_valid && !(starve && i_req_valid);
    assign grant_any = grant_i || grant_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_any)      state_next = ISSUE;
            ISSUE:   if (mem_req_ready)  state_next = WAIT;
            WAIT:    if (mem_resp_valid) state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        i_req_ready   = rst_n && (state == IDLE) && grant_i;
        d_req_ready   = rst_n && (state == IDLE) && grant_d;
        mem_req_valid = (state == ISSUE);
        i_resp_valid  = (state == WAIT) && mem_resp_valid && (owner == OWN_I);
        d_resp_valid  = (state == WAIT) && mem_resp_valid && (owner == OWN_D);
        busy          = (state != IDLE);
    end

    assign i_resp_data = mem_resp_data;
    assign d_resp_data = mem_resp_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner         <= OWN_I;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= '0;
            mem_req_wdata <= '0;
            mem_req_wmask <= '0;
        end else if ((state == IDLE) && grant_any) begin
            if (grant_d) begin
                owner         <= OWN_D;
                mem_req_we    <= d_req_we;
                mem_req_addr  <= d_req_addr;
                mem_req_wdata <= d_req_wdata;
                mem_req_wmask <= d_req_wmask;
            end else begin
                owner         <= OWN_I;
                mem_req_we    <= 1'b0;
                mem_req_addr  <= i_req_addr;
                mem_req_wdata <= '0;
                mem_req_wmask <= '0;
            end
        end
    end

    // A response outside WAIT has no owner; record it and otherwise ignore it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            protocol_err <= 1'b0;
        end else if (mem_resp_valid && (state != WAIT)) begin
            protocol_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, a small memory model
// and a monitor that checks every memory request and response as it appears.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_req_valid = 1'b0;
    logic [AW-1:0] i_req_addr = '0;
    logic          i_req_ready;
    logic          i_resp_valid;
    logic [DW-1:0] i_resp_data;
    logic          d_req_valid = 1'b0;
    logic          d_req_we = 1'b0;
    logic [AW-1:0] d_req_addr = '0;
    logic [DW-1:0] d_req_wdata = '0;
    logic [MW-1:0] d_req_wmask = '0;
    logic          d_req_ready;
    logic          d_resp_valid;
    logic [DW-1:0] d_resp_data;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic          mem_req_we;
    logic [AW-1:0] mem_req_addr;
    logic [DW-1:0] mem_req_wdata;
    logic [MW-1:0] mem_req_wmask;
    logic          mem_resp_valid = 1'b0;
    logic [DW-1:0] mem_resp_data = '0;
    logic          busy;
    logic          protocol_err;

    mem_arbiter #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (i_req_valid),
        .i_req_addr     (i_req_addr),
        .i_req_ready    (i_req_ready),
        .i_resp_valid   (i_resp_valid),
        .i_resp_data    (i_resp_data),
        .d_req_valid    (d_req_valid),
        .d_req_we       (d_req_we),
        .d_req_addr     (d_req_addr),
        .d_req_wdata    (d_req_wdata),
        .d_req_wmask    (d_req_wmask),
        .d_req_ready    (d_req_ready),
        .d_resp_valid   (d_resp_valid),
        .d_resp_data    (d_resp_data),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_req_wmask  (mem_req_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .busy           (busy),
        .protocol_err   (protocol_err)
    );

    // ---------------- clock / reset / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got no end of test, required finish before 50000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_fail = 0;
    logic [68:0] exp_mem_q[$];
    logic [31:0] exp_i_q[$];
    logic [32:0] exp_d_q[$];
    logic [31:0] mem_data_q[$];

    int i_acc_cyc = 0, d_acc_cyc = 0;
    int last_mem_cyc = 0, last_i_resp_cyc = 0, last_d_resp_cyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string got, input string req);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %s, required %s", name, got, req);
    endtask

    // ---------------- memory model ----------------
    int lat = 1;
    int stall_len = 0;
    int spur_issued = 0;
    int spur_done = 0;
    int resp_cnt = 0;
    int stall_cnt = 0;
    bit in_issue = 1'b0;

    initial forever begin
        @(negedge clk);
        mem_resp_valid = 1'b0;
        if (!rst_n) begin
            resp_cnt      = 0;
            stall_cnt     = 0;
            in_issue      = 1'b0;
            mem_req_ready = 1'b0;
            mem_data_q.delete();
        end else begin
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = (mem_data_q.size() > 0) ? mem_data_q.pop_front() : 32'h0;
                end
            end else if (spur_issued != spur_done) begin
                spur_done++;
                mem_resp_valid = 1'b1;
                mem_resp_data  = 32'hBAD0_0BAD;
            end
            if (mem_req_valid && !in_issue) begin
                stall_cnt = stall_len;
                in_issue  = 1'b1;
            end
            mem_req_ready = (stall_cnt == 0);
            if (mem_req_valid && in_issue) begin
                if (stall_cnt > 0) begin
                    stall_cnt--;
                end else begin
                    in_issue = 1'b0;
                    resp_cnt = lat;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        logic [68:0] em;
        logic [32:0] ed;
        @(negedge clk);
        #3;
        if (rst_n) begin
            if (mem_req_valid && mem_req_ready) begin
                last_mem_cyc = cyc;
                if (exp_mem_q.size() == 0) begin
                    fail_now("mem_req_unexpected", "a memory request", "none");
                end else begin
                    em = exp_mem_q.pop_front();
                    check("mem_req_fields", {mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask}, em);
                end
            end
            if (i_resp_valid) begin
                last_i_resp_cyc = cyc;
                if (exp_i_q.size() == 0) begin
                    fail_now("i_resp_unexpected", "i_resp_valid=1", "i_resp_valid=0");
                end else begin
                    check("i_resp_data", i_resp_data, exp_i_q.pop_front());
                end
            end
            if (d_resp_valid) begin
                last_d_resp_cyc = cyc;
                if (exp_d_q.size() == 0) begin
                    fail_now("d_resp_unexpected", "d_resp_valid=1", "d_resp_valid=0");
                end else begin
                    ed = exp_d_q.pop_front();
                    if (ed[32]) check("d_resp_data", d_resp_data, ed[31:0]);
                end
            end
            if (i_resp_valid && d_resp_valid) fail_now("resp_both", "both resp_valid=1", "at most one");
            if (busy) check("no_ready_when_busy", {i_req_ready, d_req_ready}, 2'b00);
        end
    end

    // ---------------- drivers ----------------
    task automatic i_send(input logic [31:0] addr);
        int n = 0;
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        forever begin
            #1;
            if (i_req_ready) begin
                i_acc_cyc = cyc;
                break;
            end
            n++;
            if (n > 300) begin
                fail_now("i_accept_timeout", "no i_req_ready", "i_req_ready within 300 cycles");
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic d_send(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wmask);
        int n = 0;
        d_req_valid = 1'b1;
        d_req_we    = we;
        d_req_addr  = addr;
        d_req_wdata = wdata;
        d_req_wmask = wmask;
        forever begin
            #1;
            if (d_req_ready) begin
                d_acc_cyc = cyc;
                break;
            end
            n++;
            if (n > 300) begin
                fail_now("d_accept_timeout", "no d_req_ready", "d_req_ready within 300 cycles");
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        forever begin
            @(negedge clk);
            #4;
            if (exp_mem_q.size() == 0 && exp_i_q.size() == 0 && exp_d_q.size() == 0 && !busy) break;
            n++;
            if (n > 300) begin
                fail_now("drain_timeout", "outstanding expectations", "all responses within 300 cycles");
                exp_mem_q.delete();
                exp_i_q.delete();
                exp_d_q.delete();
                break;
            end
        end
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int t0;

        // Reset with both requesters asserting: nothing may be offered.
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h0000_0999;
        repeat (3) @(negedge clk);
        #1;
        check("reset_outputs", {i_req_ready, d_req_ready, mem_req_valid, i_resp_valid,
                                d_resp_valid, busy, protocol_err}, 7'b0);
        check("reset_fields", {mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask}, 69'b0);
        @(negedge clk);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        // 1: lone fetch, response 3 cycles after the memory handshake.
        lat = 3;
        mem_data_q.push_back(32'hDEAD_BEEF);
        exp_mem_q.push_back({1'b0, 32'h0000_0100, 32'h0, 4'h0});
        exp_i_q.push_back(32'hDEAD_BEEF);
        i_send(32'h0000_0100);
        i_req_valid = 1'b0;
        drain();
        check("t1_mem_req_cycle", last_mem_cyc - i_acc_cyc, 1);
        check("t1_i_resp_cycle", last_i_resp_cyc - i_acc_cyc, 4);

        // 2: simultaneous I and D, D wins, I follows the cycle after D's response.
        lat = 2;
        mem_data_q.push_back(32'h2222_0000);
        mem_data_q.push_back(32'h1111_0000);
        exp_mem_q.push_back({1'b0, 32'h0000_0200, 32'h0, 4'h0});
        exp_mem_q.push_back({1'b0, 32'h0000_0104, 32'h0, 4'h0});
        exp_d_q.push_back({1'b1, 32'h2222_0000});
        exp_i_q.push_back(32'h1111_0000);
        fork
            begin
                i_send(32'h0000_0104);
                i_req_valid = 1'b0;
            end
            begin
                d_send(1'b0, 32'h0000_0200, 32'h0, 4'h0);
                d_req_valid = 1'b0;
            end
        join
        drain();
        check("t2_i_grant_after_d_resp", i_acc_cyc - last_d_resp_cyc, 1);

        // 3: D back-to-back, I waiting; starvation grants I on the third IDLE.
        lat = 1;
        mem_data_q.push_back(32'hD1D1_0001);
        mem_data_q.push_back(32'hD2D2_0002);
        mem_data_q.push_back(32'h1A1A_0003);
        mem_data_q.push_back(32'hD3D3_0004);
        exp_mem_q.push_back({1'b0, 32'h0000_0300, 32'h0, 4'h0});
        exp_mem_q.push_back({1'b0, 32'h0000_0304, 32'h0, 4'h0});
        exp_mem_q.push_back({1'b0, 32'h0000_0108, 32'h0, 4'h0});
        exp_mem_q.push_back({1'b0, 32'h0000_0308, 32'h0, 4'h0});
        exp_d_q.push_back({1'b1, 32'hD1D1_0001});
        exp_d_q.push_back({1'b1, 32'hD2D2_0002});
        exp_d_q.push_back({1'b1, 32'hD3D3_0004});
        exp_i_q.push_back(32'h1A1A_0003);
        t0 = 0;
        fork
            begin
                i_send(32'h0000_0108);
                i_req_valid = 1'b0;
            end
            begin
                d_send(1'b0, 32'h0000_0300, 32'h0, 4'h0);
                t0 = d_acc_cyc;
                d_send(1'b0, 32'h0000_0304, 32'h0, 4'h0);
                d_send(1'b0, 32'h0000_0308, 32'h0, 4'h0);
                d_req_valid = 1'b0;
            end
        join
        drain();
        check("t3_starve_grant_cycle", i_acc_cyc - t0, 6);

        // 4: memory holds off a store for 5 cycles while I is waiting.
        lat = 2;
        stall_len = 5;
        mem_data_q.push_back(32'h0);
        mem_data_q.push_back(32'h4C4C_4C4C);
        exp_mem_q.push_back({1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 4'hC});
        exp_mem_q.push_back({1'b0, 32'h0000_010C, 32'h0, 4'h0});
        exp_d_q.push_back({1'b0, 32'h0});
        exp_i_q.push_back(32'h4C4C_4C4C);
        d_send(1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 4'hC);
        d_req_valid = 1'b0;
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_010C;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t4_stall_hold", {mem_req_valid, busy, i_req_ready, d_req_ready, mem_req_ready,
                                    mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wmask},
                  {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 4'hC});
            @(negedge clk);
        end
        stall_len = 0;
        i_send(32'h0000_010C);
        i_req_valid = 1'b0;
        drain();

        // 5: partial store; ack comes back on D.
        lat = 2;
        mem_data_q.push_back(32'hFFFF_FFFF);
        exp_mem_q.push_back({1'b1, 32'h0000_0040, 32'h0000_1234, 4'b0011});
        exp_d_q.push_back({1'b0, 32'h0});
        d_send(1'b1, 32'h0000_0040, 32'h0000_1234, 4'b0011);
        d_req_valid = 1'b0;
        drain();
        check("t5_store_ack_cycle", last_d_resp_cyc - d_acc_cyc, 3);

        // 6a: stray response in IDLE sets the sticky error.
        #1;
        spur_issued++;
        repeat (2) @(negedge clk);
        #1;
        check("t6_protocol_err_set", {protocol_err, busy}, 2'b10);
        repeat (3) @(negedge clk);
        #1;
        check("t6_protocol_err_sticky", protocol_err, 1'b1);
        @(negedge clk);

        // 6b: asynchronous reset while waiting for a response.
        lat = 6;
        mem_data_q.push_back(32'h6666_6666);
        exp_mem_q.push_back({1'b0, 32'h0000_0110, 32'h0, 4'h0});
        i_send(32'h0000_0110);
        i_req_valid = 1'b0;
        @(negedge clk);
        #1;
        check("t6_busy_in_wait", busy, 1'b1);
        rst_n = 1'b0;
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        #1;
        check("t6_async_reset", {busy, protocol_err, i_req_ready, d_req_ready, mem_req_valid,
                                 i_resp_valid, d_resp_valid}, 7'b0);
        repeat (2) @(negedge clk);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("t6_post_reset_state", {busy, protocol_err}, 2'b00);
        @(negedge clk);
        lat = 1;
        mem_data_q.push_back(32'h7777_7777);
        exp_mem_q.push_back({1'b0, 32'h0000_0114, 32'h0, 4'h0});
        exp_i_q.push_back(32'h7777_7777);
        i_send(32'h0000_0114);
        i_req_valid = 1'b0;
        drain();
        check("t6_post_reset_latency", last_i_resp_cyc - i_acc_cyc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
